alu_arbiter: RTL and testbench

- Shares one combinational `alu` instance between two requesters: port 0 is the execute stage, port 1 is the string/REP micro-sequencer.
- Each request carries control word, flags and two operands. The block:
  - arbitrates between the two ports,
  - registers the winning request,
  - drives the ALU for one cycle,
  - registers result and flags,
  - returns them on a single tagged response channel with valid/ready backpressure.

---
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter sharing one combinational ALU.
// Define ALU_ARB_FIXED_PRIO_EN to make port 0 win every tie.
module alu_arbiter #(
  parameter int CNTL_W = 18,
  parameter int STAT_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CNTL_W-1:0] req0_cntl,
  input  logic [STAT_W-1:0] req0_status,
  input  logic [DATA_W-1:0] req0_opnd0,
  input  logic [DATA_W-1:0] req0_opnd1,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CNTL_W-1:0] req1_cntl,
  input  logic [STAT_W-1:0] req1_status,
  input  logic [DATA_W-1:0] req1_opnd0,
  input  logic [DATA_W-1:0] req1_opnd1,
  output logic [CNTL_W-1:0] alu_cntl,
  output logic [STAT_W-1:0] alu_status_in,
  output logic [DATA_W-1:0] alu_opnd0,
  output logic [DATA_W-1:0] alu_opnd1,
  input  logic [STAT_W-1:0] alu_status_out,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_tag,
  output logic [DATA_W-1:0] rsp_result,
  output logic [STAT_W-1:0] rsp_status,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_tag;
  logic              r_rsp_valid;
  logic              r_busy;
  logic [CNTL_W-1:0] r_cntl;
  logic [STAT_W-1:0] r_status;
  logic [DATA_W-1:0] r_opnd0;
  logic [DATA_W-1:0] r_opnd1;
  logic [DATA_W-1:0] r_rsp_result;
  logic [STAT_W-1:0] r_rsp_status;

  logic              w_idle;
  logic              w_pick1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_accept;
  logic [CNTL_W-1:0] w_cntl;
  logic [STAT_W-1:0] w_status;
  logic [DATA_W-1:0] w_opnd0;
  logic [DATA_W-1:0] w_opnd1;

  // no grant while reset is asserted, so nothing is handed off and lost
  assign w_idle = (r_state == IDLE) & rst_n;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_pick1 = req1_valid & ~req0_valid;
`else
  assign w_pick1 = req1_valid
                 & (~req0_valid | ~r_last_grant);
`endif

  assign w_gnt1   = w_idle & w_pick1;
  assign w_gnt0   = w_idle & req0_valid & ~w_pick1;
  assign w_accept = w_gnt0 | w_gnt1;

  assign w_cntl   = w_pick1 ? req1_cntl   : req0_cntl;
  assign w_status = w_pick1 ? req1_status : req0_status;
  assign w_opnd0  = w_pick1 ? req1_opnd0  : req0_opnd0;
  assign w_opnd1  = w_pick1 ? req1_opnd1  : req0_opnd1;

  assign req0_ready    = w_gnt0;
  assign req1_ready    = w_gnt1;
  assign alu_cntl      = r_cntl;
  assign alu_status_in = r_status;
  assign alu_opnd0     = r_opnd0;
  assign alu_opnd1     = r_opnd1;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_tag       = r_tag;
  assign rsp_result    = r_rsp_result;
  assign rsp_status    = r_rsp_status;
  assign busy          = r_busy;

  // issue / execute / respond sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_tag        <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_cntl       <= '0;
      r_status     <= '0;
      r_opnd0      <= '0;
      r_opnd1      <= '0;
      r_rsp_result <= '0;
      r_rsp_status <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cntl       <= w_cntl;
            r_status     <= w_status;
            r_opnd0      <= w_opnd0;
            r_opnd1      <= w_opnd1;
            r_tag        <= w_pick1;
            r_last_grant <= w_pick1;
            r_busy       <= 1'b1;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_result <= alu_result;
          r_rsp_status <= alu_status_out;
          r_rsp_valid  <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ALU model.
// cntl[0]=0 adds, 1 xors; flags {in[6:2], ZF, CF}.
module tb_alu_arbiter;

  localparam int CW = 18;
  localparam int SW = 7;
  localparam int DW = 32;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready;
  logic [CW-1:0] req0_cntl;
  logic [SW-1:0] req0_status;
  logic [DW-1:0] req0_opnd0, req0_opnd1;
  logic          req1_valid, req1_ready;
  logic [CW-1:0] req1_cntl;
  logic [SW-1:0] req1_status;
  logic [DW-1:0] req1_opnd0, req1_opnd1;
  logic [CW-1:0] alu_cntl;
  logic [SW-1:0] alu_status_in, alu_status_out;
  logic [DW-1:0] alu_opnd0, alu_opnd1, alu_result;
  logic          rsp_valid, rsp_ready, rsp_tag, busy;
  logic [DW-1:0] rsp_result;
  logic [SW-1:0] rsp_status;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_cntl(req0_cntl), .req0_status(req0_status),
    .req0_opnd0(req0_opnd0), .req0_opnd1(req0_opnd1),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_cntl(req1_cntl), .req1_status(req1_status),
    .req1_opnd0(req1_opnd0), .req1_opnd1(req1_opnd1),
    .alu_cntl(alu_cntl), .alu_status_in(alu_status_in),
    .alu_opnd0(alu_opnd0), .alu_opnd1(alu_opnd1),
    .alu_status_out(alu_status_out), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_tag(rsp_tag), .rsp_result(rsp_result),
    .rsp_status(rsp_status), .busy(busy)
  );

  logic [DW:0] w_sum;
  always_comb begin
    w_sum = '0;
    alu_result = '0;
    if (alu_cntl[0]) begin
      alu_result = alu_opnd0 ^ alu_opnd1;
    end else begin
      w_sum = {1'b0, alu_opnd0} + {1'b0, alu_opnd1};
      alu_result = w_sum[DW-1:0];
    end
    alu_status_out = {alu_status_in[6:2],
                      alu_result == '0, w_sum[DW]};
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [CW-1:0] c,
                      input logic [SW-1:0] s,
                      input logic [DW-1:0] a,
                      input logic [DW-1:0] b);
    req0_cntl = c; req0_status = s;
    req0_opnd0 = a; req0_opnd1 = b;
  endtask

  task automatic set1(input logic [CW-1:0] c,
                      input logic [SW-1:0] s,
                      input logic [DW-1:0] a,
                      input logic [DW-1:0] b);
    req1_cntl = c; req1_status = s;
    req1_opnd0 = a; req1_opnd1 = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] held;
    bit            exp1;

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b0;
    set0('0, '0, '0, '0);
    set1('0, '0, '0, '0);
    tick();
    tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tag", rsp_tag, 0);
    chk("rst_alu_cntl", alu_cntl, 0);
    chk("rst_alu_op0", alu_opnd0, 0);
    chk("rst_rsp_result", rsp_result, 0);
    rst_n = 1'b1;
    tick();

    // single ADD: 0xFFFFFFFF + 1 -> 0, CF=1 ZF=1
    set0(18'h0, 7'h0, 32'hFFFF_FFFF, 32'h1);
    req0_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("add_r0_ready", req0_ready, 1);
    chk("add_r1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("add_exec_busy", busy, 1);
    chk("add_exec_valid", rsp_valid, 0);
    chk("add_exec_op0", alu_opnd0, 32'hFFFF_FFFF);
    chk("add_exec_ready", req0_ready, 0);
    tick();
    chk("add_rsp_valid", rsp_valid, 1);
    chk("add_rsp_tag", rsp_tag, 0);
    chk("add_rsp_result", rsp_result, 0);
    chk("add_rsp_status", rsp_status, 7'b0000011);
    tick();
    chk("add_idle_valid", rsp_valid, 0);
    chk("add_idle_busy", busy, 0);
    chk("add_alu_hold", alu_opnd0, 32'hFFFF_FFFF);

    // tie right after reset goes to port 0
    do_reset();
    set0(18'h1, 7'h0, 32'h0000_A5A5, 32'h0000_0F0F);
    set1(18'h0, 7'h0, 32'd3, 32'd4);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("tie_r0_ready", req0_ready, 1);
    chk("tie_r1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("tie_exec_r1", req1_ready, 0);
    tick();
    chk("tie_tag0", rsp_tag, 0);
    chk("tie_res0", rsp_result, 32'h0000_AAAA);
    chk("tie_st0", rsp_status, 0);
    tick();
    chk("tie_r1_granted", req1_ready, 1);
    chk("tie_r0_idle", req0_ready, 0);
    tick();
    tick();
    chk("tie_tag1", rsp_tag, 1);
    chk("tie_res1", rsp_result, 32'd7);
    req1_valid = 1'b0;
    tick();

    // both held valid: third tie then alternation
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp1 = FIXED ? 1'b0 : i[0];
      #1;
      chk("alt_idle_busy", busy, 0);
      chk("alt_r0_ready", req0_ready, !exp1);
      chk("alt_r1_ready", req1_ready, exp1);
      tick();
      chk("alt_exec_busy", busy, 1);
      tick();
      chk("alt_rsp_busy", busy, 1);
      chk("alt_tag", rsp_tag, exp1);
      chk("alt_res", rsp_result,
          exp1 ? 32'd7 : 32'h0000_AAAA);
      tick();
    end
    req0_valid = 1'b0;
    #1;
    chk("drop_r1_ready", req1_ready, 1);
    req1_valid = 1'b0;
    #1;

    // backpressure with req1 waiting
    rsp_ready = 1'b0;
    set0(18'h0, 7'b1010100, 32'h10, 32'h20);
    req0_valid = 1'b1;
    #1;
    chk("bp_r0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    tick();
    held = rsp_result;
    chk("bp_res", rsp_result, 32'h30);
    chk("bp_status", rsp_status, 7'b1010100);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_stable", rsp_result, held);
      chk("bp_r0", req0_ready, 0);
      chk("bp_r1", req1_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_r1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;

    // reset during EXEC aborts the op
    chk("mid_exec_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_valid", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_alu_cntl", alu_cntl, 0);
    chk("mid_alu_op0", alu_opnd0, 0);
    chk("mid_alu_op1", alu_opnd1, 0);
    chk("mid_alu_st", alu_status_in, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_rsp", rsp_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
